riscv_wb_arbiter: RTL

Writeback arbiter that owns the single write port of the integer register file. It merges single-cycle ALU results with handshaked long-latency results (load/mul-div), buffers long-latency results that lose arbitration, and drives a registered `rd` write port. It also keeps a pending-write scoreboard that decode uses to stall on long-latency destinations.

---
 rtl/riscv_wb_arbiter_pkg.sv | 9 +
 rtl/riscv_wb_arbiter_if.sv | 25 ++
 rtl/riscv_wb_fifo.sv | 36 +++
 rtl/riscv_wb_arbiter.sv | 57 +++++
 4 files changed

// File: rtl/riscv_wb_arbiter_pkg.sv
// riscv_wb_arbiter_pkg: shared widths and writeback source flags
package riscv_wb_arbiter_pkg;
    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;
endpackage

// File: rtl/riscv_wb_arbiter_if.sv
// riscv_wb_arbiter_if: result sources, issue tracking and register-file write port
interface riscv_wb_arbiter_if #(parameter int XLEN = riscv_wb_arbiter_pkg::RegBus);
    import riscv_wb_arbiter_pkg::*;
    logic                  alu_valid_i;
    logic [RegAddrBus-1:0] alu_rd_i;
    logic [XLEN-1:0]       alu_val_i;
    logic                  mem_valid_i;
    logic [RegAddrBus-1:0] mem_rd_i;
    logic [XLEN-1:0]       mem_val_i;
    logic                  mem_ready_o;
    logic                  issue_i;
    logic [RegAddrBus-1:0] issue_rd_i;
    logic                  rd_we_o;
    logic [RegAddrBus-1:0] rd_idx_o;
    logic [XLEN-1:0]       rd_val_o;
    logic [31:0]           busy_o;
    modport master (
        output alu_valid_i, alu_rd_i, alu_val_i, mem_valid_i, mem_rd_i, mem_val_i, issue_i, issue_rd_i,
        input  mem_ready_o, rd_we_o, rd_idx_o, rd_val_o, busy_o
    );
    modport slave (
        input  alu_valid_i, alu_rd_i, alu_val_i, mem_valid_i, mem_rd_i, mem_val_i, issue_i, issue_rd_i,
        output mem_ready_o, rd_we_o, rd_idx_o, rd_val_o, busy_o
    );
endinterface

// File: rtl/riscv_wb_fifo.sv
// riscv_wb_fifo: DEPTH-entry FIFO with wrap-around pointers and explicit count
module riscv_wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    assign head = mem[rd_ptr];
    assign full = count == CW'(DEPTH);
    // storage needs no reset: count gates every read
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;
    // pointers wrap at DEPTH-1; count tracks occupancy directly
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
endmodule

// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter: owns the register-file write port and the pending-write scoreboard
module riscv_wb_arbiter import riscv_wb_arbiter_pkg::*; #(
    parameter int XLEN  = RegBus,
    parameter int DEPTH = 2
) (
    input logic              clk,
    input logic              rst,
    riscv_wb_arbiter_if.slave wb
);
    localparam int W  = RegAddrBus + XLEN;
    localparam int CW = $clog2(DEPTH + 1);
    logic                  full, empty, accept, pop, push, bypass, we_n;
    logic [W-1:0]          head;
    logic [CW-1:0]         count;
    logic [RegAddrBus-1:0] idx_n;
    logic [XLEN-1:0]       val_n;
    logic [31:0]           clr, set;
    wb_src_e               src_q;
    assign wb.mem_ready_o = !full;
    assign empty          = count == '0;
    assign accept         = wb.mem_valid_i & !full;
    assign pop            = !wb.alu_valid_i & !empty;
    assign bypass         = !wb.alu_valid_i & empty & accept;
    assign push           = accept & !bypass;
    assign {idx_n, val_n} = wb.alu_valid_i ? {wb.alu_rd_i, wb.alu_val_i} :
                            !empty         ? head : {wb.mem_rd_i, wb.mem_val_i};
    assign we_n = (wb.alu_valid_i | !empty | accept) & (idx_n != '0);
    assign clr  = (wb.rd_we_o && src_q == WB_SRC_MEM) ? 32'd1 << wb.rd_idx_o : '0;
    assign set  = (wb.issue_i && wb.issue_rd_i != '0) ? 32'd1 << wb.issue_rd_i : '0;
    riscv_wb_fifo #(.WIDTH(W), .DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({wb.mem_rd_i, wb.mem_val_i}),
        .head  (head),
        .count (count),
        .full  (full)
    );
    // write port: ALU first, then buffered results, then a bypassed mem result
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wb.rd_we_o  <= 1'b0;
            wb.rd_idx_o <= '0;
            wb.rd_val_o <= '0;
            src_q       <= WB_SRC_ALU;
        end else begin
            wb.rd_we_o  <= we_n;
            wb.rd_idx_o <= idx_n;
            wb.rd_val_o <= val_n;
            src_q       <= wb.alu_valid_i ? WB_SRC_ALU : WB_SRC_MEM;
        end
    // scoreboard: a new issue overrides the clear from a same-index commit
    always_ff @(posedge clk or posedge rst)
        if (rst) wb.busy_o <= '0;
        else     wb.busy_o <= (wb.busy_o & ~clr) | set;
endmodule
